// File: rtl/fp_addsub_ctrl_if.sv
// Control/status bundle between the FP add/sub sequencer and its datapath.
// Handshake: start is sampled only while the sequencer is idle (busy=0, done=0);
// an accepted start raises busy the next cycle and ends with exactly one done pulse.
interface fp_addsub_ctrl_if;
  logic start;
  logic greater;
  logic sign_gt;
  logic sign_lt;
  logic mant4;
  logic mant5;
  logic en_gt;
  logic en_ld;
  logic en_addsub;
  logic en_norm;
  logic en_out;
  logic ld_AB;
  logic add_sub;
  logic norm_lr;
  logic busy;
  logic done;
  logic err;

  modport master (
    output start, greater, sign_gt, sign_lt, mant4, mant5,
    input  en_gt, en_ld, en_addsub, en_norm, en_out,
    input  ld_AB, add_sub, norm_lr, busy, done, err
  );

  modport slave (
    input  start, greater, sign_gt, sign_lt, mant4, mant5,
    output en_gt, en_ld, en_addsub, en_norm, en_out,
    output ld_AB, add_sub, norm_lr, busy, done, err
  );
endinterface

// File: rtl/fp_addsub_ctrl.sv
// Sequencer for a floating-point add/sub datapath: compare, load, add/sub,
// normalize (bounded by NORM_MAX shifts, at most 7), output, done.
module fp_addsub_ctrl #(
  parameter int NORM_MAX = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  fp_addsub_ctrl_if.slave        bus,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMP    = 3'd1,
    S_LOAD   = 3'd2,
    S_ADDSUB = 3'd3,
    S_NORM   = 3'd4,
    S_OUT    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       en_gt_q, en_gt_d;
  logic       en_ld_q, en_ld_d;
  logic       en_addsub_q, en_addsub_d;
  logic       en_out_q, en_out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       normalized;
  logic       norm_abort;
  logic       norm_pulse;

  always_comb begin
    normalized  = !bus.mant5 && bus.mant4;
    norm_abort  = !normalized && (cnt_q == 3'(NORM_MAX));
    norm_pulse  = (state_q == S_NORM) && !normalized && !norm_abort;
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CMP;
          err_d   = 1'b0;
        end
      end
      S_CMP:    state_d = S_LOAD;
      S_LOAD:   state_d = S_ADDSUB;
      S_ADDSUB: begin
        state_d = S_NORM;
        cnt_d   = 3'd0;
      end
      S_NORM: begin
        if (normalized) begin
          state_d = S_OUT;
        end else if (norm_abort) begin
          state_d = S_OUT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_OUT:    state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Step enables are registered alongside the state so they are clean decodes.
    en_gt_d     = (state_d == S_CMP);
    en_ld_d     = (state_d == S_LOAD);
    en_addsub_d = (state_d == S_ADDSUB);
    en_out_d    = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      en_gt_q     <= 1'b0;
      en_ld_q     <= 1'b0;
      en_addsub_q <= 1'b0;
      en_out_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      en_gt_q     <= en_gt_d;
      en_ld_q     <= en_ld_d;
      en_addsub_q <= en_addsub_d;
      en_out_q    <= en_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Datapath flags only become valid the cycle after each step, so the
  // qualifiers and the normalize pulse are gated combinationally by state.
  assign bus.en_gt     = en_gt_q;
  assign bus.en_ld     = en_ld_q;
  assign bus.en_addsub = en_addsub_q;
  assign bus.en_out    = en_out_q;
  assign bus.en_norm   = norm_pulse;
  assign bus.ld_AB     = en_ld_q & bus.greater;
  assign bus.add_sub   = en_addsub_q & ~(bus.sign_gt ^ bus.sign_lt);
  assign bus.norm_lr   = norm_pulse & ~bus.mant5;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Directed bench for fp_addsub_ctrl with a small behavioral 8-bit FP datapath
// (sign[7], exponent[6:3], fraction[2:0] with hidden one).
module tb_fp_addsub_ctrl;

  logic       clk;
  logic       clr;
  logic [2:0] dbg_state;

  fp_addsub_ctrl_if bus ();

  fp_addsub_ctrl #(.NORM_MAX(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath model ----------------
  logic [7:0] op_a, op_b, s_out;
  logic       force_den;
  logic       gt_r, sg_r, sl_r, s_r, zero_r, zforce_r;
  logic [3:0] eb_r, e_r;
  logic [4:0] mb_r, ms_r, m_r;
  logic [7:0] big, sml;
  logic [4:0] sml_al, sum;

  assign big    = bus.ld_AB ? op_a : op_b;
  assign sml    = bus.ld_AB ? op_b : op_a;
  assign sml_al = {2'b01, sml[2:0]} >> (big[6:3] - sml[6:3]);
  assign sum    = bus.add_sub ? (mb_r + ms_r) : (mb_r - ms_r);

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      gt_r <= 0; sg_r <= 0; sl_r <= 0; s_r <= 0; zero_r <= 0; zforce_r <= 0;
      eb_r <= 0; e_r <= 0; mb_r <= 0; ms_r <= 0; m_r <= 0; s_out <= 0;
    end else begin
      if (bus.en_gt) gt_r <= (op_a[6:0] >= op_b[6:0]);
      if (bus.en_ld) begin
        sg_r <= big[7]; sl_r <= sml[7]; eb_r <= big[6:3];
        mb_r <= {2'b01, big[2:0]}; ms_r <= sml_al;
      end
      if (bus.en_addsub) begin
        m_r <= sum; e_r <= eb_r; s_r <= sg_r; zero_r <= (sum == 5'd0); zforce_r <= 1'b0;
      end
      if (bus.en_norm) begin
        if (zero_r) zforce_r <= 1'b1;
        else if (bus.norm_lr) begin m_r <= m_r << 1; e_r <= e_r - 4'd1; end
        else begin m_r <= m_r >> 1; e_r <= e_r + 4'd1; end
      end
      if (bus.en_out) s_out <= zero_r ? 8'h00 : {s_r, e_r, m_r[2:0]};
    end
  end

  assign bus.greater = gt_r;
  assign bus.sign_gt = sg_r;
  assign bus.sign_lt = sl_r;
  assign bus.mant5   = force_den ? 1'b0 : (zforce_r ? 1'b0 : m_r[4]);
  assign bus.mant4   = force_den ? 1'b0 : (zforce_r ? 1'b1 : m_r[3]);

  logic [10:0] outs;
  assign outs = {bus.en_gt, bus.en_ld, bus.en_addsub, bus.en_norm, bus.en_out,
                 bus.ld_AB, bus.add_sub, bus.norm_lr, bus.busy, bus.done, bus.err};

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int   done_cyc, n_norm, n_left, n_gt, n_out, onehot_bad, qual_bad, busy_bad;
  logic ld_seen, as_seen;

  // Pulses start, then follows the operation cycle by cycle (cycle 1 = first
  // cycle after the start-sampling edge) until done or a 40-cycle budget.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic poke);
    int cyc;
    op_a = a; op_b = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; done_cyc = 0; n_norm = 0; n_left = 0; n_gt = 0; n_out = 0;
    onehot_bad = 0; qual_bad = 0; busy_bad = 0; ld_seen = 1'bx; as_seen = 1'bx;
    while (done_cyc == 0 && cyc < 40) begin
      if ($countones({bus.en_gt, bus.en_ld, bus.en_addsub, bus.en_norm, bus.en_out}) > 1)
        onehot_bad++;
      if ((bus.ld_AB && !bus.en_ld) || (bus.add_sub && !bus.en_addsub) ||
          (bus.norm_lr && !bus.en_norm))
        qual_bad++;
      if (bus.en_gt)     n_gt++;
      if (bus.en_out)    n_out++;
      if (bus.en_ld)     ld_seen = bus.ld_AB;
      if (bus.en_addsub) as_seen = bus.add_sub;
      if (bus.en_norm) begin
        n_norm++;
        if (bus.norm_lr) n_left++;
      end
      if (bus.done) begin
        done_cyc = cyc;
        if (bus.busy) busy_bad++;
      end else if (!bus.busy) busy_bad++;
      bus.start = poke && (cyc == 2);
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_op(input string tag, input int exp_done, input int exp_norm,
                          input int exp_left, input logic exp_ld, input logic exp_as,
                          input logic [7:0] exp_s, input logic exp_err);
    check({tag, " done_cycle"}, done_cyc, exp_done);
    check({tag, " en_norm_pulses"}, n_norm, exp_norm);
    check({tag, " norm_left_pulses"}, n_left, exp_left);
    check({tag, " ld_AB"}, {31'd0, ld_seen}, {31'd0, exp_ld});
    check({tag, " add_sub"}, {31'd0, as_seen}, {31'd0, exp_as});
    check({tag, " en_gt_en_out_once"}, n_gt * 16 + n_out, 17);
    check({tag, " onehot_violations"}, onehot_bad, 0);
    check({tag, " qualifier_violations"}, qual_bad, 0);
    check({tag, " busy_profile"}, busy_bad, 0);
    check({tag, " result"}, {24'd0, s_out}, {24'd0, exp_s});
    check({tag, " err"}, {31'd0, bus.err}, {31'd0, exp_err});
  endtask

  initial begin
    int dn;
    clr = 1'b1; bus.start = 1'b0; force_den = 1'b0; op_a = 8'h00; op_b = 8'h00;
    #3;
    check("reset_outputs_async", {21'd0, outs}, 32'd0);
    check("reset_state", {29'd0, dbg_state}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    check("idle_outputs", {21'd0, outs}, 32'd0);

    run_op(8'h48, 8'h40, 1'b1);
    check_op("add_no_norm", 6, 0, 0, 1'b1, 1'b1, 8'h4C, 1'b0);
    run_op(8'h40, 8'h40, 1'b0);
    check_op("add_carry", 7, 1, 0, 1'b1, 1'b1, 8'h48, 1'b0);
    run_op(8'h48, 8'hC0, 1'b0);
    check_op("sub_shift_left", 7, 1, 1, 1'b1, 1'b0, 8'h40, 1'b0);
    run_op(8'h10, 8'h40, 1'b0);
    check_op("b_larger", 6, 0, 0, 1'b0, 1'b1, 8'h40, 1'b0);
    run_op(8'h40, 8'hC0, 1'b0);
    check_op("zero_result", 7, 1, 1, 1'b1, 1'b0, 8'h00, 1'b0);

    force_den = 1'b1;
    run_op(8'h48, 8'h40, 1'b0);
    force_den = 1'b0;
    check("abort done_cycle", done_cyc, 10);
    check("abort en_norm_pulses", n_norm, 4);
    check("abort norm_left_pulses", n_left, 4);
    check("abort en_out_once", n_out, 1);
    check("abort err", {31'd0, bus.err}, 32'd1);

    run_op(8'h48, 8'h40, 1'b0);
    check_op("err_cleared_by_start", 6, 0, 0, 1'b1, 1'b1, 8'h4C, 1'b0);

    force_den = 1'b1;
    run_op(8'h48, 8'h40, 1'b0);
    check("abort2 err", {31'd0, bus.err}, 32'd1);
    #3 clr = 1'b1;
    #1 check("clr_idle_err_async", {31'd0, bus.err}, 32'd0);
    @(posedge clk); #1 clr = 1'b0;

    // Abandon an operation while it is shifting in NORM.
    op_a = 8'h48; op_b = 8'h40;
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_clr_state_norm", {29'd0, dbg_state}, 32'd4);
    check("pre_clr_en_norm", {31'd0, bus.en_norm}, 32'd1);
    #3 clr = 1'b1;
    #1;
    check("clr_mid_norm_outputs", {21'd0, outs}, 32'd0);
    check("clr_mid_norm_state", {29'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0; force_den = 1'b0;
    dn = 0;
    repeat (2) begin
      if (bus.done || bus.busy) dn++;
      @(posedge clk); #1;
    end
    check("clr_no_done", dn, 0);
    run_op(8'h48, 8'h40, 1'b0);
    check_op("after_clr", 6, 0, 0, 1'b1, 1'b1, 8'h4C, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_addsub_ctrl.md
FP_ADDSUB_CTRL -- requirements
Module: fp_addsub_ctrl

Interface
REQ-001 Parameter NORM_MAX, default 4: maximum en_norm pulses allowed per operation before abort.
REQ-002 clk  input  1  clock; all state changes occur on its rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request one add/sub of the operands currently on the datapath A/B inputs.
REQ-005 greater  input  1  datapath flag: magnitude(A) >= magnitude(B), valid the cycle after en_gt.
REQ-006 sign_gt, sign_lt  input  1 each  datapath operand signs, valid the cycle after en_ld.
REQ-007 mant4, mant5  input  1 each  datapath result mantissa bits [3] and [4], valid the cycle after en_addsub/en_norm.
REQ-008 en_gt, en_ld, en_addsub, en_norm, en_out  output  1 each  one-hot datapath step enables.
REQ-009 ld_AB  output  1  1 = load A as larger operand, 0 = load B as larger.
REQ-010 add_sub  output  1  1 = add mantissas, 0 = subtract.
REQ-011 norm_lr  output  1  1 = shift left (exponent -1), 0 = shift right (exponent +1).
REQ-012 busy  output  1  high from the cycle after start is accepted until the cycle before done.
REQ-013 done  output  1  single-cycle completion pulse.
REQ-014 err  output  1  sticky abort flag for the last operation; cleared on next accepted start.

Function
REQ-015 The FSM SHALL have states IDLE, CMP, LOAD, ADDSUB, NORM, OUT, DONE, encoded in a registered state vector.
REQ-016 IDLE: all enables 0, busy 0; start=1 at a rising edge -> CMP, err cleared; start=0 -> stay.
REQ-017 CMP: en_gt=1 for exactly one cycle -> LOAD.
REQ-018 LOAD: en_ld=1, ld_AB=greater (as registered by the datapath at the end of CMP) -> ADDSUB.
REQ-019 ADDSUB: en_addsub=1, add_sub = ~(sign_gt ^ sign_lt) -> NORM; norm counter reset to 0.
REQ-020 NORM, normalized condition (mant5=0, mant4=1): en_norm=0 -> OUT.
REQ-021 NORM, mant5=1: en_norm=1, norm_lr=0, counter+1, stay in NORM.
REQ-022 NORM, mant5=0 and mant4=0: en_norm=1, norm_lr=1, counter+1, stay in NORM (covers zero result; the datapath forces the normalized flags).
REQ-023 NORM, not normalized and counter = NORM_MAX: en_norm=0, err set to 1 -> OUT.
REQ-024 OUT: en_out=1 for one cycle -> DONE.
REQ-025 DONE: done=1 for one cycle, busy=0 -> IDLE; a new start is accepted in the following IDLE cycle only.
REQ-026 At most one en_* output SHALL be high in any cycle.
REQ-027 ld_AB, add_sub and norm_lr SHALL be 0 whenever their associated enable is 0.
REQ-028 start SHALL be ignored in every state other than IDLE.
REQ-029 Latency: done SHALL assert 6 cycles after the start-sampling edge plus 1 cycle per en_norm pulse.
REQ-030 The norm counter SHALL be 3 bits wide and never wrap; NORM_MAX SHALL be at most 7.

Reset
REQ-031 clr=1 SHALL force state IDLE, counter 0, and all outputs 0 (including err) immediately, regardless of clk.
REQ-032 clr asserted mid-operation SHALL abandon the operation with no done pulse; the first start after clr deasserts SHALL begin a fresh CMP.

Verification
REQ-033 A=0x48, B=0x40, start: en_gt, en_ld(ld_AB=1), en_addsub(add_sub=1), no en_norm, en_out; done 6 cycles after start; s=0x4C; err=0.
REQ-034 A=0x40, B=0x40: mant5=1 after addsub -> one en_norm with norm_lr=0; done at cycle 7; s=0x48.
REQ-035 A=0x48, B=0xC0: add_sub=0; mant4=0 -> one en_norm with norm_lr=1; done at cycle 7; s=0x40.
REQ-036 A=0x10, B=0x40: greater=0 -> ld_AB=0 during LOAD; A=0x40, B=0xC0: zero result -> one en_norm pulse, s=0x00.
REQ-037 Bench-forced mant5=0, mant4=0 held: exactly NORM_MAX(4) en_norm pulses, then err=1, en_out, done at cycle 10.
REQ-038 clr pulse during NORM: all outputs 0 at once, no done; start re-pulsed 2 cycles later: nominal sequence and result.
